vec_issue_queue: RTL and testbench

- Buffers vector instructions, with their rs1/rs2 operands, arriving from the scalar processor.
- Issues them one at a time to vector_processor_datapth and runs the done/ack handshake back to the scalar side.
- Sits between the scalar interface and the datapath/controller pair, replacing the single-entry valid/ready handshake.
- The scalar core can therefore run ahead by up to DEPTH instructions.

---
 rtl/vec_issue_pkg.sv | 25 ++
 rtl/vec_issue_fifo.sv | 66 ++++++
 rtl/vec_issue_queue.sv | 107 ++++++++++
 tb/tb_vec_issue_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_issue_pkg.sv
// -----------------------------------------------------------------------------
// vec_issue_pkg
// Shared types for the vector issue queue.
//   VEC_XLEN      : default instruction/operand width (tracks the vector
//                   processor definitions).
//   issue_state_e : issue FSM states IDLE / EXEC / ACK.
//   issue_entry_t : one queued instruction with its two scalar operands.
// -----------------------------------------------------------------------------
package vec_issue_pkg;

  localparam int VEC_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [VEC_XLEN-1:0] inst;
    logic [VEC_XLEN-1:0] rs1;
    logic [VEC_XLEN-1:0] rs2;
  } issue_entry_t;

endpackage

// File: rtl/vec_issue_fifo.sv
// -----------------------------------------------------------------------------
// vec_issue_fifo
// Circular buffer holding queued (not yet issued) instructions.
//   clk, reset : clock, asynchronous active-high reset
//   push/wdata : write request and data; ignored when full or flushing
//   pop        : remove the head; ignored when empty or flushing
//   flush      : drop every queued entry (rd_ptr catches up with wr_ptr)
//   rdata      : current head entry
//   full/empty : derived from count
//   count      : number of queued entries
// -----------------------------------------------------------------------------
module vec_issue_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Flush takes priority over both push and pop in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; count/pointers alone decide what is valid,
  // which keeps the array free of reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/vec_issue_queue.sv
// -----------------------------------------------------------------------------
// vec_issue_queue
// Buffers vector instructions from the scalar core and issues them one at a
// time to the vector datapath, then runs the done/ack handshake back.
//   clk, reset                  : clock, asynchronous active-high reset
//   inst_valid, instruction,
//   rs1_data, rs2_data          : instruction offer from the scalar core
//   vec_pro_ready               : queue can accept (depends on count only)
//   flush                       : drop all queued, not-yet-issued entries
//   issue_valid, issue_inst,
//   issue_rs1, issue_rs2        : instruction currently executing
//   inst_done                   : datapath finished the issued instruction
//   vec_pro_ack                 : completion acknowledge to the scalar core
//   scalar_pro_ready            : scalar core accepts the ack
//   q_count                     : queued entries, excluding the in-flight one
// -----------------------------------------------------------------------------
module vec_issue_queue
  import vec_issue_pkg::*;
#(
  parameter int XLEN  = VEC_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_valid,
  input  logic [XLEN-1:0]            instruction,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  output logic                       vec_pro_ready,
  input  logic                       flush,
  output logic                       issue_valid,
  output logic [XLEN-1:0]            issue_inst,
  output logic [XLEN-1:0]            issue_rs1,
  output logic [XLEN-1:0]            issue_rs2,
  input  logic                       inst_done,
  output logic                       vec_pro_ack,
  input  logic                       scalar_pro_ready,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int EW = 3 * XLEN;

  issue_state_e  state;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [EW-1:0] head;

  // Ready looks only at the registered count, so no path from inst_valid
  // (or from a same-cycle pop) reaches any output.
  assign vec_pro_ready = !fifo_full;
  // Flush in IDLE suppresses the pop: the FSM stays idle with an empty queue.
  assign pop           = (state == IDLE) && !fifo_empty && !flush;

  vec_issue_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inst_valid),
    .pop   (pop),
    .flush (flush),
    .wdata ({instruction, rs1_data, rs2_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      issue_valid <= 1'b0;
      issue_inst  <= '0;
      issue_rs1   <= '0;
      issue_rs2   <= '0;
      vec_pro_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {issue_inst, issue_rs1, issue_rs2} <= head;
            issue_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          // issue_* keep their value after completion; only valid drops.
          if (inst_done) begin
            issue_valid <= 1'b0;
            vec_pro_ack <= 1'b1;
            state       <= ACK;
          end
        end
        ACK: begin
          if (scalar_pro_ready) begin
            vec_pro_ack <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_vec_issue_queue
// Self-checking bench for vec_issue_queue. A reference model (queue of
// pending entries plus FSM state) predicts q_count/ready/valid/ack; entries
// popped by the model go to a scoreboard and are compared when the DUT raises
// issue_valid.
// -----------------------------------------------------------------------------
module tb_vec_issue_queue;
  import vec_issue_pkg::*;

  localparam int XLEN  = VEC_XLEN;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            inst_valid;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            vec_pro_ready;
  logic            flush;
  logic            issue_valid;
  logic [XLEN-1:0] issue_inst;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  logic            inst_done;
  logic            vec_pro_ack;
  logic            scalar_pro_ready;
  logic [CW-1:0]   q_count;

  vec_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_valid       (inst_valid),
    .instruction      (instruction),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .vec_pro_ready    (vec_pro_ready),
    .flush            (flush),
    .issue_valid      (issue_valid),
    .issue_inst       (issue_inst),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .inst_done        (inst_done),
    .vec_pro_ack      (vec_pro_ack),
    .scalar_pro_ready (scalar_pro_ready),
    .q_count          (q_count)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  issue_entry_t fifo_q[$];   // model of queued entries
  issue_entry_t exp_q[$];    // scoreboard: entries the model has issued
  issue_entry_t cur;         // expected contents of the issue registers
  issue_state_e m_state;
  logic         prev_valid;

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic issue_entry_t rnd();
    issue_entry_t e;
    e.inst = $urandom;
    e.rs1  = $urandom;
    e.rs2  = $urandom;
    return e;
  endfunction

  // Compare DUT outputs against the model, sampled 1 time unit after the edge.
  task automatic verify();
    check("q_count", XLEN'(q_count), XLEN'(fifo_q.size()));
    check("ready", XLEN'(vec_pro_ready), XLEN'(fifo_q.size() != DEPTH));
    check("issue_valid", XLEN'(issue_valid), XLEN'(m_state == EXEC));
    check("ack", XLEN'(vec_pro_ack), XLEN'(m_state == ACK));
    if (issue_valid && !prev_valid) begin
      if (exp_q.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
      else cur = exp_q.pop_front();
    end
    check("issue_inst", issue_inst, cur.inst);
    check("issue_rs1", issue_rs1, cur.rs1);
    check("issue_rs2", issue_rs2, cur.rs2);
    prev_valid = issue_valid;
  endtask

  // Drive one cycle of stimulus, advance the model, clock, then verify.
  task automatic step(input bit v, input issue_entry_t e, input bit d,
                      input bit s, input bit f);
    bit acc;
    bit pop;
    inst_valid       = v;
    instruction      = e.inst;
    rs1_data         = e.rs1;
    rs2_data         = e.rs2;
    inst_done        = d;
    scalar_pro_ready = s;
    flush            = f;
    acc = v && (fifo_q.size() != DEPTH) && !f;
    pop = (m_state == IDLE) && (fifo_q.size() != 0) && !f;
    if (f) fifo_q.delete();
    else begin
      if (pop) exp_q.push_back(fifo_q.pop_front());
      if (acc) fifo_q.push_back(e);
    end
    case (m_state)
      IDLE:    if (pop) m_state = EXEC;
      EXEC:    if (d)   m_state = ACK;
      default: if (s)   m_state = IDLE;
    endcase
    @(posedge clk);
    #1;
    inst_valid       = 1'b0;
    inst_done        = 1'b0;
    scalar_pro_ready = 1'b0;
    flush            = 1'b0;
    verify();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, rnd(), 0, 0, 0);
  endtask

  // Complete everything outstanding; the model bounds the loop.
  task automatic drain();
    for (int i = 0; i < 60 && !(fifo_q.size() == 0 && m_state == IDLE); i++)
      step(0, rnd(), 1, 1, 0);
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_issue_valid", XLEN'(issue_valid), '0);
    check("rst_ack", XLEN'(vec_pro_ack), '0);
    check("rst_q_count", XLEN'(q_count), '0);
    check("rst_issue_inst", issue_inst, '0);
    check("rst_issue_rs1", issue_rs1, '0);
    check("rst_issue_rs2", issue_rs2, '0);
    fifo_q.delete();
    exp_q.delete();
    m_state    = IDLE;
    cur        = '0;
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    verify();
  endtask

  initial begin
    issue_entry_t e1;
    reset = 1'b1; inst_valid = 1'b0; instruction = '0; rs1_data = '0;
    rs2_data = '0; flush = 1'b0; inst_done = 1'b0; scalar_pro_ready = 1'b0;
    m_state = IDLE; cur = '0; prev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    verify();

    // Single instruction: latency 2, done at cycle 5, ack at 6, idle at 7.
    e1.inst = 32'h0000_5057; e1.rs1 = 32'd5; e1.rs2 = 32'd7;
    step(1, e1, 0, 0, 0);               // cycle 0
    step(0, rnd(), 0, 0, 0);            // cycle 1
    check("t1_lat2_valid", XLEN'(issue_valid), 32'd1);
    check("t1_lat2_inst", issue_inst, 32'h0000_5057);
    idle(3);                            // cycles 2..4
    step(0, rnd(), 1, 0, 0);            // cycle 5: inst_done
    check("t1_ack", XLEN'(vec_pro_ack), 32'd1);
    step(0, rnd(), 0, 1, 0);            // cycle 6: scalar_pro_ready
    check("t1_ack_clear", XLEN'(vec_pro_ack), 32'd0);
    idle(2);

    // Fill: 5 accepted (4 queued + 1 in flight), 6th ignored; in-order drain.
    for (int i = 0; i < 6; i++) begin
      step(1, rnd(), 0, 0, 0);
      if (i == 4) check("t2_full_ready", XLEN'(vec_pro_ready), 32'd0);
    end
    check("t2_q_count", XLEN'(q_count), 32'd4);
    drain();
    // Second pass wraps the pointers well past 8 total pushes.
    for (int i = 0; i < 6; i++) step(1, rnd(), 0, 0, 0);
    drain();

    // Simultaneous push and pop in IDLE with q_count=2.
    step(1, rnd(), 0, 0, 0);
    step(0, rnd(), 0, 0, 0);
    step(0, rnd(), 1, 0, 0);
    step(1, rnd(), 0, 0, 0);
    step(1, rnd(), 0, 1, 0);
    check("t3_idle_q2", XLEN'(q_count), 32'd2);
    step(1, rnd(), 0, 0, 0);
    check("t3_pushpop_q2", XLEN'(q_count), 32'd2);
    drain();

    // Flush with 3 queued and 1 in EXEC; same-cycle push is dropped.
    for (int i = 0; i < 4; i++) step(1, rnd(), 0, 0, 0);
    check("t4_pre_flush", XLEN'(q_count), 32'd3);
    step(1, rnd(), 0, 0, 1);
    check("t4_flushed", XLEN'(q_count), 32'd0);
    check("t4_inflight", XLEN'(issue_valid), 32'd1);
    step(0, rnd(), 1, 0, 0);
    step(0, rnd(), 0, 1, 0);
    idle(3);

    // Reset during EXEC, then during ACK.
    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0, 0);
    do_reset();
    step(1, rnd(), 0, 0, 0);
    step(1, rnd(), 0, 0, 0);
    step(1, rnd(), 1, 0, 0);
    check("t5_in_ack", XLEN'(vec_pro_ack), 32'd1);
    do_reset();

    // Ack held for 10 cycles: no new issue, pushes accepted until full.
    step(1, rnd(), 0, 0, 0);
    step(0, rnd(), 0, 0, 0);
    step(0, rnd(), 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, rnd(), 0, 0, 0);
    check("t6_hold_ack", XLEN'(vec_pro_ack), 32'd1);
    check("t6_full", XLEN'(q_count), 32'd4);
    step(0, rnd(), 0, 1, 0);
    // Flush in IDLE with a non-empty queue beats the pop.
    step(0, rnd(), 0, 0, 1);
    check("t7_idle_flush", XLEN'(issue_valid), 32'd0);
    idle(3);

    check("scoreboard_empty", XLEN'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
